// File: rtl/display_arbiter.sv
// Two-requester arbiter for the shared 4-digit seven-segment display:
// round-robin ownership with a minimum hold slice and optional leading-zero blanking.
module display_arbiter #(
  parameter int          HOLD_WIDTH  = 20,
  parameter int          HOLD_CYCLES = 1000000,
  parameter logic [15:0] IDLE_NUMBER = 16'h0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [1:0]  req,
  input  logic [15:0] num0,
  input  logic [3:0]  en0,
  input  logic [15:0] num1,
  input  logic [3:0]  en1,
  input  logic        blank_lz,
  output logic [1:0]  grant,
  output logic [15:0] number,
  output logic [3:0]  digit_enables
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  localparam logic [HOLD_WIDTH-1:0] HOLD_MAX = HOLD_WIDTH'(HOLD_CYCLES - 1);

  state_t                  state_reg;
  state_t                  state_next;
  logic                    last_reg;
  logic [HOLD_WIDTH-1:0]   hold_cnt_reg;
  logic [15:0]             number_reg;
  logic [3:0]              digit_enables_reg;
  logic [15:0]             sel_num;
  logic [3:0]              sel_en;
  logic [3:0]              lz_mask;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        case (req)
          2'b01:   state_next = OWN0;
          2'b10:   state_next = OWN1;
          2'b11:   state_next = last_reg ? OWN0 : OWN1;
          default: state_next = IDLE;
        endcase
      end
      OWN0: begin
        // A dropped request hands over at once; otherwise the slice must expire.
        if (!req[0])
          state_next = req[1] ? OWN1 : IDLE;
        else if (req[1] && hold_cnt_reg == HOLD_MAX)
          state_next = OWN1;
      end
      OWN1: begin
        if (!req[1])
          state_next = req[0] ? OWN0 : IDLE;
        else if (req[0] && hold_cnt_reg == HOLD_MAX)
          state_next = OWN0;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs follow the owner that will hold the display after this edge.
  always_comb begin
    sel_num = (state_next == OWN1) ? num1 : num0;
    sel_en  = (state_next == OWN1) ? en1  : en0;
    lz_mask = 4'b1111;
    if (blank_lz) begin
      lz_mask[3] = (sel_num[15:12] != 4'h0);
      lz_mask[2] = (sel_num[15:8]  != 8'h00);
      lz_mask[1] = (sel_num[15:4]  != 12'h000);
      lz_mask[0] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg         <= IDLE;
      last_reg          <= 1'b1;
      hold_cnt_reg      <= '0;
      number_reg        <= IDLE_NUMBER;
      digit_enables_reg <= 4'b0000;
    end else begin
      state_reg <= state_next;

      if (state_next != state_reg || state_next == IDLE)
        hold_cnt_reg <= '0;
      else if (hold_cnt_reg != HOLD_MAX)
        hold_cnt_reg <= hold_cnt_reg + HOLD_WIDTH'(1);

      if (state_next != state_reg && state_reg != IDLE)
        last_reg <= (state_reg == OWN1);

      if (state_next == IDLE) begin
        number_reg        <= IDLE_NUMBER;
        digit_enables_reg <= 4'b0000;
      end else begin
        number_reg        <= sel_num;
        digit_enables_reg <= sel_en & lz_mask;
      end
    end
  end

  assign grant         = state_reg;
  assign number        = number_reg;
  assign digit_enables = digit_enables_reg;

endmodule

// File: doc/display_arbiter.md
Name: display_arbiter

Overview:
- Shares the single 4-digit seven-segment display between two requesters, e.g. CPU coprocessor port writes (requester 0) and a local status/counter source (requester 1).
- Drives the `number`/`digit_enables` inputs of the display multiplex driver.
- Grants ownership with a minimum hold time-slice and round-robin fairness.
- Optionally blanks leading zeros of the granted value.

Parameters:
- HOLD_WIDTH, 20, width of the hold counter.
- HOLD_CYCLES, 1000000, minimum cycles an owner keeps the display while the other side requests. Range 1 .. 2^HOLD_WIDTH-1.
- IDLE_NUMBER, 16'h0000, value driven on `number` when no owner.

Ports:
- clock  input  1  system clock
- reset_n  input  1  synchronous active-low reset, sampled on rising clock
- req  input  2  level request; req[i]=1 means requester i wants the display
- num0  input  16  requester 0 hex value (4 nibbles, nibble 0 = rightmost digit)
- en0  input  4  requester 0 digit enables
- num1  input  16  requester 1 hex value
- en1  input  4  requester 1 digit enables
- blank_lz  input  1  1 = suppress leading zero digits
- grant  output  2  one-hot owner, 2'b00 = idle (registered)
- number  output  16  value to display driver (registered)
- digit_enables  output  4  enables to display driver (registered)

Behaviour:
- One clock, no other clock domains. Reset is synchronous and active-low: on a rising `clock` with reset_n=0, all state goes to reset values.
- Reset values:
  - state=IDLE, grant=2'b00
  - number=IDLE_NUMBER, digit_enables=4'b0000
  - hold_cnt=0
  - last=1, so requester 0 wins the first tie.
- States: IDLE, OWN0, OWN1. `grant` equals the state encoding (IDLE 00, OWN0 01, OWN1 10).
- From IDLE:
  - If only req[i]=1, go to OWNi.
  - If both are set, go to OWN of the requester != last.
  - Otherwise stay in IDLE.
- From OWNi, evaluated in priority order:
  - (a) req[i]=0: go to OWNj if req[j]=1, else IDLE.
  - (b) req[j]=1 and hold_cnt==HOLD_CYCLES-1: go to OWNj (time-slice expiry).
  - (c) otherwise stay in OWNi.
- last <= i whenever leaving OWNi.
- hold_cnt:
  - Cleared to 0 on every state change and while in IDLE.
  - Otherwise increments by 1, saturating at HOLD_CYCLES-1 (no wrap).
  - Consequence: if the other side raises req after saturation, the switch happens at the next edge.
- HOLD_CYCLES=1: a requesting other side takes over after exactly 1 owned cycle (ping-pong every cycle while both request).
- Output datapath: registered, computed from next_state at the same edge as the state update.
  - Next owner i: number <= num_i, digit_enables <= en_i & lz_mask.
  - Next state IDLE: number <= IDLE_NUMBER, digit_enables <= 0.
  - grant, number and digit_enables therefore always change on the same edge.
  - Latency from a num/en input change of the current owner to the outputs is 1 cycle.
- Leading-zero mask, from the selected 16-bit value v:
  - blank_lz=0: lz_mask = 4'b1111.
  - blank_lz=1: lz_mask[3]=0 iff v[15:12]==0; lz_mask[2]=0 iff v[15:8]==0; lz_mask[1]=0 iff v[15:4]==0; lz_mask[0]=1 always.
  - So 0x0000 shows a single "0".
- The non-owner's inputs have no effect on outputs.
- req dropping and rising in the same cycle for different requesters is handled by rule (a) (immediate handover, no hold wait).
- Reset mid-ownership returns to IDLE and blank output on the next edge, regardless of req.

Test Plan:
- HOLD_CYCLES=4. Reset with req=11 -> grant=00, number=IDLE_NUMBER, digit_enables=0 during reset. First edge after release -> grant=01 (last=1 tie-break).
- HOLD_CYCLES=4, req=11 held steady -> grant sequence 01,01,01,01,10,10,10,10,01..., four cycles per owner. number tracks num0=16'h1234 / num1=16'hABCD on the same edges as grant.
- req=01 for 10 cycles, then req=11 -> grant switches to 10 on the next edge (hold saturated). Then req=10 for 2 cycles, then req=00 -> grant=00 after 1 edge, digit_enables=0.
- Owner 0 with en0=4'hF, blank_lz=1, num0 stepped 16'h0000, 16'h0007, 16'h00A5, 16'h0100, 16'h1000 -> digit_enables 0001, 0001, 0011, 0111, 1111, each 1 cycle after the input change. blank_lz=0 -> 1111 throughout.
- In OWN1 with req=11 and hold_cnt=1, drop req[1] -> grant=01 on the next edge with no hold wait. en0=4'b0101, blank_lz=0 -> digit_enables=0101 on the same edge.
- In OWN0 with req=11, assert reset_n=0 for 1 cycle -> grant=00, outputs blank. After release with req=11 -> grant=01 (last reset to 1).
